// File: rtl/cp0_except.sv
// CP0 exception registers and MEM-stage exception prioritisation for the pipeline controller.
// Define CP0_TIMER_EN to implement Count/Compare and the timer interrupt (TI into IP7).
module cp0_except #(
  parameter logic [31:0] RESET_STATUS = 32'h0040_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid_i,
  input  logic [31:0] mem_pc_i,
  input  logic        mem_in_delayslot_i,
  input  logic        exc_if_adel_i,
  input  logic        exc_ri_i,
  input  logic        exc_ov_i,
  input  logic        exc_sys_i,
  input  logic        exc_bp_i,
  input  logic        exc_tr_i,
  input  logic        exc_adel_i,
  input  logic        exc_ades_i,
  input  logic        exc_eret_i,
  input  logic [31:0] mem_bad_vaddr_i,
  input  logic [5:0]  int_i,
  input  logic        cp0_we_i,
  input  logic [4:0]  cp0_waddr_i,
  input  logic [31:0] cp0_wdata_i,
  input  logic [4:0]  cp0_raddr_i,
  output logic [31:0] cp0_rdata_o,
  output logic [31:0] excepttype_o,
  output logic [31:0] cp0_epc_o,
  output logic [31:0] current_pc_o,
  output logic        timer_int_o
);

  localparam logic [4:0]  RegBadVAddr = 5'd8;
  localparam logic [4:0]  RegCount    = 5'd9;
  localparam logic [4:0]  RegCompare  = 5'd11;
  localparam logic [4:0]  RegStatus   = 5'd12;
  localparam logic [4:0]  RegCause    = 5'd13;
  localparam logic [4:0]  RegEpc      = 5'd14;
  localparam logic [31:0] StatusWMask = 32'h0000_ff03;

  logic [31:0] status_q, epc_q, badvaddr_q, count_q, compare_q;
  logic [4:0]  exccode_q;
  logic [1:0]  ip_sw_q;
  logic        bd_q, ti_q;
  logic [7:0]  ip;
  logic        int_pend, commit, eret, wr_ok;
  logic [31:0] code;

  assign ip       = {int_i[5] | ti_q, int_i[4:0], ip_sw_q};
  assign int_pend = status_q[0] & ~status_q[1] & (|(status_q[15:8] & ip)) & mem_valid_i;

  always_comb begin
    code = 32'h0;
    if (rst || !mem_valid_i) code = 32'h0;
    else if (int_pend)       code = 32'h1;
    else if (exc_if_adel_i)  code = 32'h4;
    else if (exc_ri_i)       code = 32'ha;
    else if (exc_ov_i)       code = 32'hc;
    else if (exc_tr_i)       code = 32'hd;
    else if (exc_sys_i)      code = 32'h8;
    else if (exc_bp_i)       code = 32'h9;
    else if (exc_adel_i)     code = 32'h4;
    else if (exc_ades_i)     code = 32'h5;
    else if (exc_eret_i)     code = 32'he;
  end

  assign commit = (code != 32'h0) && (code != 32'he);
  assign eret   = (code == 32'he);
  // MTC0 is dropped whenever the MEM instruction raises anything.
  assign wr_ok  = cp0_we_i && (code == 32'h0);

  always_ff @(posedge clk) begin
    if (rst) begin
      status_q   <= RESET_STATUS;
      epc_q      <= 32'h0;
      badvaddr_q <= 32'h0;
      exccode_q  <= 5'h0;
      ip_sw_q    <= 2'h0;
      bd_q       <= 1'b0;
    end else if (commit) begin
      status_q[1] <= 1'b1;
      bd_q        <= mem_in_delayslot_i;
      exccode_q   <= int_pend ? 5'h0 : code[4:0];
      epc_q       <= mem_in_delayslot_i ? mem_pc_i - 32'd4 : mem_pc_i;
      // Code 4 from the fetch side only when if_adel won; otherwise it is a data AdEL.
      if (code == 32'h4 && exc_if_adel_i)        badvaddr_q <= mem_pc_i;
      else if (code == 32'h4 || code == 32'h5)   badvaddr_q <= mem_bad_vaddr_i;
    end else if (eret) begin
      status_q[1] <= 1'b0;
    end else if (wr_ok) begin
      case (cp0_waddr_i)
        RegStatus: status_q <= (status_q & ~StatusWMask) | (cp0_wdata_i & StatusWMask);
        RegCause:  ip_sw_q  <= cp0_wdata_i[9:8];
        RegEpc:    epc_q    <= cp0_wdata_i;
        default:   ;
      endcase
    end
  end

`ifdef CP0_TIMER_EN
  logic        toggle_q, armed_q, cnt_wr, cmp_wr, cnt_chg, ti_d;
  logic [31:0] count_d;

  always_comb begin
    cnt_wr  = wr_ok && (cp0_waddr_i == RegCount);
    cmp_wr  = wr_ok && (cp0_waddr_i == RegCompare);
    cnt_chg = cnt_wr || toggle_q;
    count_d = toggle_q ? count_q + 32'd1 : count_q;
    if (cnt_wr) count_d = cp0_wdata_i;
    ti_d = ti_q;
    if (cmp_wr) ti_d = 1'b0;
    else if (cnt_chg && count_d == compare_q && (compare_q != 32'h0 || armed_q)) ti_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q   <= 32'h0;
      compare_q <= 32'h0;
      toggle_q  <= 1'b0;
      armed_q   <= 1'b0;
      ti_q      <= 1'b0;
    end else begin
      count_q  <= count_d;
      toggle_q <= ~toggle_q;
      ti_q     <= ti_d;
      if (cmp_wr) begin
        compare_q <= cp0_wdata_i;
        armed_q   <= 1'b1;
      end
    end
  end
`else
  assign count_q   = 32'h0;
  assign compare_q = 32'h0;
  assign ti_q      = 1'b0;
`endif

  always_comb begin
    cp0_rdata_o = 32'h0;
    case (cp0_raddr_i)
      RegBadVAddr: cp0_rdata_o = badvaddr_q;
      RegCount:    cp0_rdata_o = count_q;
      RegCompare:  cp0_rdata_o = compare_q;
      RegStatus:   cp0_rdata_o = status_q;
      RegCause:    cp0_rdata_o = {bd_q, ti_q, 14'h0, ip, 1'b0, exccode_q, 2'b00};
      RegEpc:      cp0_rdata_o = epc_q;
      default:     cp0_rdata_o = 32'h0;
    endcase
  end

  assign excepttype_o = code;
  assign cp0_epc_o    = (cp0_we_i && cp0_waddr_i == RegEpc) ? cp0_wdata_i : epc_q;
  assign current_pc_o = mem_pc_i;
  assign timer_int_o  = ti_q;

endmodule
